eep_image_xfer: RTL and testbench

- Host-side initiator for the ATmega EEPROM peripheral's external access port (ext_eep_*).
- Dumps the whole EEPROM image to a host byte stream (save to SD) and restores an image from a host byte stream (load from SD).
- Sits between the MiSTer HPS/ioctl glue and the EEPROM peripheral.
- Owns ext_eep_data_en while busy and requests a CPU hold so the core cannot access the EEPROM concurrently.

---
 rtl/eep_xfer_pkg.sv | 7 +
 rtl/eep_image_xfer.sv | 102 ++++++++++
 tb/tb_eep_image_xfer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/eep_xfer_pkg.sv
// eep_xfer_pkg: shared state encoding and default sizes for the EEPROM image transfer block.
package eep_xfer_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RD_OUT, WR_IN, WR_STROBE, FINISH} xfer_state_t;
    localparam int EEP_SIZE_DEF = 512;
    localparam int ADDR_W_DEF = 17;
    localparam int CSUM_W = 16;
endpackage

// File: rtl/eep_image_xfer.sv
// eep_image_xfer: dumps/restores the whole EEPROM image through the peripheral's external access port.
module eep_image_xfer
    import eep_xfer_pkg::*;
#(
    parameter int EEP_SIZE = EEP_SIZE_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_dump,
    input  logic              cmd_load,
    input  logic              abort,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CSUM_W-1:0] checksum,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ext_eep_addr,
    output logic [7:0]        ext_eep_data_in,
    output logic              ext_eep_data_wr,
    input  logic [7:0]        ext_eep_data_out,
    output logic              ext_eep_data_rd,
    output logic              ext_eep_data_en
);
    localparam int LAT_W = READ_LAT > 1 ? $clog2(READ_LAT) : 1;

    xfer_state_t state, nxt;
    logic [ADDR_W-1:0] addr;
    logic [LAT_W-1:0]  lat_cnt;
    logic              last, lat_done, start, abort_ok;

    assign last     = addr == ADDR_W'(EEP_SIZE - 1);
    assign lat_done = lat_cnt == LAT_W'(READ_LAT - 1);
    assign start    = state == IDLE && (cmd_dump || cmd_load);
    assign abort_ok = abort && busy && state != FINISH;

    assign busy            = state != IDLE;
    assign cpu_hold        = busy;
    assign ext_eep_data_en = busy;
    assign ext_eep_addr    = busy ? addr : '0;
    assign ext_eep_data_rd = state == RD_ADDR || state == RD_WAIT;
    assign ext_eep_data_wr = state == WR_STROBE;
    assign out_valid       = state == RD_OUT;
    assign in_ready        = state == WR_IN;
    assign done            = state == FINISH;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Abort preempts every handshake; a strobe already on the bus still finishes its cycle.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = cmd_dump ? RD_ADDR : cmd_load ? WR_IN : IDLE;
            RD_ADDR:   nxt = abort ? FINISH : lat_done ? RD_WAIT : RD_ADDR;
            RD_WAIT:   nxt = abort ? FINISH : RD_OUT;
            RD_OUT:    nxt = abort ? FINISH : !out_ready ? RD_OUT : last ? FINISH : RD_ADDR;
            WR_IN:     nxt = abort ? FINISH : in_valid ? WR_STROBE : WR_IN;
            WR_STROBE: nxt = (abort || last) ? FINISH : WR_IN;
            FINISH:    nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr            <= '0;
            lat_cnt         <= '0;
            checksum        <= '0;
            aborted         <= 1'b0;
            out_data        <= '0;
            ext_eep_data_in <= '0;
        end else begin
            lat_cnt <= (state == RD_ADDR && !lat_done && !abort) ? lat_cnt + 1'b1 : '0;
            if (start) begin
                addr     <= '0;
                checksum <= '0;
                aborted  <= 1'b0;
            end
            if (abort_ok) aborted <= 1'b1;
            if (state == RD_WAIT && !abort) begin
                out_data <= ext_eep_data_out;
                checksum <= checksum + CSUM_W'(ext_eep_data_out);
            end
            if (state == WR_IN && in_valid && !abort) begin
                ext_eep_data_in <= in_data;
                checksum        <= checksum + CSUM_W'(in_data);
            end
            if (((state == RD_OUT && out_ready) || state == WR_STROBE) && !abort && !last)
                addr <= addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_eep_image_xfer.sv
// tb_eep_image_xfer: randomized scoreboard bench with an EEPROM array model and a reference image.
module tb_eep_image_xfer;
    logic        clk = 0, rst = 1, cmd_dump = 0, cmd_load = 0, abort = 0;
    logic [7:0]  out_data, in_data = 0, ext_eep_data_in, ext_eep_data_out;
    logic        out_valid, out_ready = 0, in_valid = 0, in_ready, busy, done, aborted, cpu_hold;
    logic [15:0] checksum;
    logic [16:0] ext_eep_addr;
    logic        ext_eep_data_wr, ext_eep_data_rd, ext_eep_data_en;

    eep_image_xfer dut (
        .clk(clk), .rst(rst), .cmd_dump(cmd_dump), .cmd_load(cmd_load), .abort(abort),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done), .aborted(aborted), .checksum(checksum), .cpu_hold(cpu_hold),
        .ext_eep_addr(ext_eep_addr), .ext_eep_data_in(ext_eep_data_in),
        .ext_eep_data_wr(ext_eep_data_wr), .ext_eep_data_out(ext_eep_data_out),
        .ext_eep_data_rd(ext_eep_data_rd), .ext_eep_data_en(ext_eep_data_en)
    );

    always #5 clk = ~clk;

    // EEPROM array with one-cycle registered read
    logic [7:0] eep [512];
    logic       pre = 1;
    always @(posedge clk) begin
        if (pre) for (int i = 0; i < 512; i++) eep[i] <= 8'(i);
        if (ext_eep_data_rd) ext_eep_data_out <= eep[ext_eep_addr[8:0]];
        if (ext_eep_data_wr) eep[ext_eep_addr[8:0]] <= ext_eep_data_in;
    end

    int          checks = 0, errors = 0, rd_cnt = 0, done_cnt = 0, in_rdy_cnt = 0;
    logic [7:0]  ref_mem [512];
    logic [7:0]  ld [512];
    logic [7:0]  exp_rd [$];
    logic [24:0] exp_wr [$];
    logic [16:0] exp_done [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    logic       pv = 0, pr = 0;
    logic [7:0] pd = 0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("hold_en_eq_busy", {cpu_hold, ext_eep_data_en}, {busy, busy});
            if (!ext_eep_data_en) chk("addr_idle_zero", ext_eep_addr, 0);
            if (pv && !pr && out_valid) chk("out_data_stable", out_data, pd);
            if (in_ready) in_rdy_cnt++;
            if (out_valid && out_ready && !abort) begin
                rd_cnt++;
                if (exp_rd.size() == 0) unexpected("dump_byte_extra");
                else chk("dump_byte", out_data, exp_rd.pop_front());
            end
            if (ext_eep_data_wr) begin
                if (exp_wr.size() == 0) unexpected("write_strobe_extra");
                else chk("write_addr_data", {ext_eep_addr, ext_eep_data_in}, exp_wr.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) unexpected("done_extra");
                else chk("done_aborted_checksum", {aborted, checksum}, exp_done.pop_front());
            end
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic d, input logic l);
        cmd_dump = d;
        cmd_load = l;
        tick();
        cmd_dump = 0;
        cmd_load = 0;
    endtask

    // mode 0: out_ready held high; mode 1: one cycle on, three off
    task automatic run(input int mode, input int stop_n, input int load_at);
        int st = rd_cnt;
        int dn = done_cnt;
        bit fin = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            out_ready = (stop_n >= 0 && rd_cnt - st >= stop_n) ? 1'b0 : (mode == 0 || c % 4 == 0);
            cmd_load = (c == load_at);
            tick();
            cmd_load = 0;
            fin = done_cnt != dn || (stop_n >= 0 && rd_cnt - st >= stop_n && out_valid);
        end
        out_ready = 0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=no_event required=done_or_stop");
        end
    endtask

    task automatic exp_dump(input int n_bytes, input int n_sum, input bit ab, input bit wd);
        logic [15:0] s = 0;
        for (int i = 0; i < n_bytes; i++) exp_rd.push_back(ref_mem[i]);
        for (int i = 0; i < n_sum; i++) s += 16'(ref_mem[i]);
        if (wd) exp_done.push_back({ab, s});
    endtask

    task automatic load(input int n_abort);
        int cnt = n_abort > 0 ? n_abort : 512;
        logic [15:0] s = 0;
        logic hs;
        for (int i = 0; i < cnt; i++) begin
            exp_wr.push_back({17'(i), ld[i]});
            s += 16'(ld[i]);
            ref_mem[i] = ld[i];
        end
        exp_done.push_back({n_abort > 0, s});
        start(0, 1);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            in_valid = 1;
            in_data = ld[i];
            hs = 0;
            for (int c = 0; c < 50 && !hs; c++) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 0;
            if (!hs) chk("load_handshake_timeout", hs, 1);
        end
        if (n_abort > 0) begin
            abort = 1;
            in_valid = 1;
            in_data = 8'hFF;
            tick();
            abort = 0;
            in_valid = 0;
        end
        run(0, -1, -1);
    endtask

    task automatic mem_compare();
        int mism = 0;
        for (int i = 0; i < 512; i++) if (eep[i] !== ref_mem[i]) mism++;
        chk("eeprom_image", mism, 0);
    endtask

    initial begin
        int irdy;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i);
        repeat (3) tick();
        pre = 0;
        chk("reset_outputs", {out_data, out_valid, in_ready, busy, done, aborted, checksum, cpu_hold,
            ext_eep_addr, ext_eep_data_in, ext_eep_data_wr, ext_eep_data_rd, ext_eep_data_en}, 0);
        rst = 0;
        tick();

        exp_dump(512, 512, 0, 1);
        start(1, 0);
        run(0, -1, -1);
        chk("dump_ramp_checksum", checksum, 16'hFF00);

        for (int i = 0; i < 512; i++) ld[i] = 8'hA5;
        load(0);
        chk("load_a5_checksum", checksum, 16'h4A00);
        mem_compare();

        for (int i = 0; i < 512; i++) ld[i] = 8'($urandom);
        load(0);
        mem_compare();
        exp_dump(512, 512, 0, 1);
        start(1, 0);
        run(1, -1, -1);

        irdy = in_rdy_cnt;
        exp_dump(512, 512, 0, 1);
        start(1, 1);
        run(0, -1, 50);
        chk("no_in_ready_during_dump", in_rdy_cnt - irdy, 0);

        for (int i = 0; i < 512; i++) ld[i] = 8'($urandom);
        load(10);
        chk("abort_idle_state", {busy, ext_eep_data_en, aborted}, 3'b001);
        mem_compare();

        exp_dump(5, 6, 1, 1);
        start(1, 0);
        chk("aborted_cleared_on_start", aborted, 0);
        run(0, 5, -1);
        abort = 1;
        out_ready = 1;
        tick();
        abort = 0;
        out_ready = 0;
        run(0, -1, -1);

        exp_dump(100, 0, 0, 0);
        start(1, 0);
        run(0, 100, -1);
        chk("stop_addr", ext_eep_addr, 100);
        rst = 1;
        tick();
        chk("midreset_outputs", {out_data, out_valid, in_ready, busy, done, aborted, checksum, cpu_hold,
            ext_eep_addr, ext_eep_data_in, ext_eep_data_wr, ext_eep_data_rd, ext_eep_data_en}, 0);
        rst = 0;
        chk("midreset_pending", exp_rd.size() + exp_done.size(), 0);
        exp_dump(512, 512, 0, 1);
        start(1, 0);
        chk("restart_addr", ext_eep_addr, 0);
        run(0, -1, -1);

        repeat (3) tick();
        chk("leftover_expectations", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
